// File: rtl/port_io_pkg.sv
// Shared definitions for the port_tx_link serial-output peripheral:
// control/status bit positions, FSM encoding and the reset status value.
package port_io_pkg;

    localparam int unsigned CTRL_REQ       = 0;
    localparam int unsigned CTRL_EN        = 1;
    localparam int unsigned CTRL_FLUSH     = 2;
    localparam int unsigned CTRL_PAR_ODD   = 3;
    localparam int unsigned CTRL_PAR_FORCE = 4;

    localparam int unsigned ST_ACK    = 0;
    localparam int unsigned ST_FULL   = 1;
    localparam int unsigned ST_EMPTY  = 2;
    localparam int unsigned ST_BUSY   = 3;
    localparam int unsigned ST_LVL_LO = 4;
    localparam int unsigned ST_LVL_HI = 6;
    localparam int unsigned ST_PERR   = 7;

    localparam logic [7:0] STATUS_RST = 8'h04;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_t;

    // Even parity bit for odd=0, odd parity bit for odd=1.
    function automatic logic parity_bit(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

endpackage

// File: rtl/port_fifo.sv
// Small synchronous byte FIFO with show-ahead read data and registered
// full/empty/level flags; flush empties it in one cycle.
module port_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic       i_flush,
    input  logic [7:0] i_wr_data,
    output logic [7:0] o_rd_data,
    output logic       o_full,
    output logic       o_empty,
    output logic [2:0] o_level
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [2:0]    r_level;
    logic          r_full;
    logic          r_empty;
    logic [2:0]    w_level_next;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_push = i_push & ~r_full & ~i_flush;
    assign w_do_pop  = i_pop & ~r_empty & ~i_flush;

    always_comb begin
        w_level_next = r_level;
        if (w_do_push && !w_do_pop) begin
            w_level_next = r_level + 3'd1;
        end else if (w_do_pop && !w_do_push) begin
            w_level_next = r_level - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_level <= w_level_next;
            r_full  <= (w_level_next == 3'(DEPTH));
            r_empty <= (w_level_next == 3'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = r_full;
    assign o_empty   = r_empty;
    assign o_level   = r_level;

endmodule

// File: rtl/port_tx_link.sv
// CPU port-mapped byte transmitter: toggle handshake into a FIFO, 8N1 serial out.
// Define PORT_TX_PARITY_EN for an extra parity bit (8E1/8O1) and a forced-error line test.
module port_tx_link
    import port_io_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ctrl_in,
    input  logic [7:0] data_in,
    output logic [7:0] status_out,
    output logic       tx_out
);
    localparam logic [7:0] BAUD_LAST = 8'(CLKS_PER_BIT - 1);

    logic [7:0] r_ctrl_q;
    logic [7:0] r_data_q;
    logic       r_ack;
    logic       r_busy;
    tx_state_t  r_state;
    tx_state_t  w_state_next;
    logic [7:0] r_baud;
    logic [2:0] r_bit;
    logic [7:0] r_shift;

    logic       w_pending;
    logic       w_push;
    logic       w_pop;
    logic       w_flush;
    logic       w_en;
    logic       w_can_start;
    logic       w_baud_done;
    logic       w_tx;
    logic       w_par_bit;
    logic       w_par_err;
    logic       w_unused_ctrl;
    logic       w_fifo_full;
    logic       w_fifo_empty;
    logic [2:0] w_fifo_level;
    logic [7:0] w_fifo_rd;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl_q <= '0;
            r_data_q <= '0;
        end else begin
            r_ctrl_q <= ctrl_in;
            r_data_q <= data_in;
        end
    end

    assign w_flush     = r_ctrl_q[CTRL_FLUSH];
    assign w_en        = r_ctrl_q[CTRL_EN];
    assign w_pending   = r_ctrl_q[CTRL_REQ] ^ r_ack;
    // Registered full: a pop this cycle only frees the slot for next cycle's push.
    assign w_push      = w_pending & ~w_flush & ~w_fifo_full;
    assign w_can_start = w_en & ~w_fifo_empty & ~w_flush;
    assign w_baud_done = (r_baud == BAUD_LAST);

    port_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_flush   (w_flush),
        .i_wr_data (r_data_q),
        .o_rd_data (w_fifo_rd),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_level   (w_fifo_level)
    );

    always_ff @(posedge clk) begin
        if (reset)       r_ack <= 1'b0;
        else if (w_push) r_ack <= ~r_ack;
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_can_start) w_state_next = S_START;
            S_START:  if (w_baud_done) w_state_next = S_DATA;
            S_DATA: begin
                if (w_baud_done && r_bit == 3'd7) begin
`ifdef PORT_TX_PARITY_EN
                    w_state_next = S_PARITY;
`else
                    w_state_next = S_STOP;
`endif
                end
            end
            S_PARITY: if (w_baud_done) w_state_next = S_STOP;
            // Last stop cycle chains straight into the next start bit.
            S_STOP:   if (w_baud_done) w_state_next = w_can_start ? S_START : S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_tx  = 1'b1;
        w_pop = 1'b0;
        unique case (r_state)
            S_IDLE:   w_pop = w_can_start;
            S_START:  w_tx  = 1'b0;
            S_DATA:   w_tx  = r_shift[0];
            S_PARITY: w_tx  = w_par_bit;
            S_STOP:   w_pop = w_baud_done & w_can_start;
            default:  w_tx  = 1'b1;
        endcase
    end

    assign tx_out = w_tx;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            if (r_state == S_IDLE || w_baud_done) r_baud <= '0;
            else                                  r_baud <= r_baud + 8'd1;
            if (w_pop) begin
                r_shift <= w_fifo_rd;
                r_bit   <= '0;
            end else if (r_state == S_DATA && w_baud_done) begin
                r_shift <= r_shift >> 1;
                r_bit   <= r_bit + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_busy <= 1'b0;
        else       r_busy <= (w_state_next != S_IDLE);
    end

`ifdef PORT_TX_PARITY_EN
    logic r_par_bit;
    logic r_par_force;
    logic r_par_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_par_bit   <= 1'b0;
            r_par_force <= 1'b0;
        end else if (w_pop) begin
            r_par_bit   <= parity_bit(w_fifo_rd, r_ctrl_q[CTRL_PAR_ODD]) ^ r_ctrl_q[CTRL_PAR_FORCE];
            r_par_force <= r_ctrl_q[CTRL_PAR_FORCE];
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_flush) begin
            r_par_err <= 1'b0;
        end else if (r_state == S_STOP && w_baud_done && r_par_force) begin
            r_par_err <= 1'b1;
        end
    end

    assign w_par_bit     = r_par_bit;
    assign w_par_err     = r_par_err;
    assign w_unused_ctrl = ^r_ctrl_q[7:5];
`else
    assign w_par_bit     = 1'b1;
    assign w_par_err     = 1'b0;
    assign w_unused_ctrl = ^r_ctrl_q[7:3];
`endif

    assign status_out = {w_par_err, w_fifo_level, r_busy, w_fifo_empty, w_fifo_full, r_ack};

endmodule

// File: tb/tb_port_tx_link.sv
// Directed self-checking bench for port_tx_link (CLKS_PER_BIT=4, FIFO_DEPTH=4).
module tb_port_tx_link;

`ifdef PORT_TX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ctrl_in;
    logic [7:0] data_in;
    logic [7:0] status_out;
    logic       tx_out;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    logic [7:0]  ctrl_bits;
    logic        req;
    logic        old_req;
    logic [7:0]  st0, st1;

    port_tx_link #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .ctrl_in    (ctrl_in),
        .data_in    (data_in),
        .status_out (status_out),
        .tx_out     (tx_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        ctrl_in = ctrl_bits | {7'b0, req};
    endtask

    task automatic send(input logic [7:0] d);
        data_in = d;
        req = ~req;
        drive();
        repeat (3) tick();
    endtask

    task automatic wait_start(input string tag);
        int n = 0;
        while (tx_out !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, {7'b0, tx_out}, 8'h00);
    endtask

    task automatic check_frame(input logic [7:0] d, input logic pbit,
                               output logic [7:0] s0, output logic [7:0] s1);
        logic [10:0] bits;
        int nb;
        if (PAR_EN) begin
            bits = {1'b1, pbit, d, 1'b0};
            nb = 11;
        end else begin
            bits = {1'b0, 1'b1, d, 1'b0};
            nb = 10;
        end
        s0 = '0;
        s1 = '0;
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < 4; c++) begin
                if (b == 0 && c == 0) s0 = status_out;
                if (b == 0 && c == 1) s1 = status_out;
                chk($sformatf("frame%02h_bit%0d_c%0d", d, b, c), {7'b0, tx_out}, {7'b0, bits[b]});
                tick();
            end
        end
    endtask

    task automatic check_idle(input string tag, input int cycles);
        int lows = 0;
        repeat (cycles) begin
            if (tx_out !== 1'b1) lows++;
            tick();
        end
        chk(tag, 8'(lows), 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a0, a1;
        reset = 1'b1;
        ctrl_in = '0;
        data_in = '0;
        req = 1'b0;
        ctrl_bits = '0;
        repeat (2) tick();
        chk("rst_status", status_out, 8'h04);
        chk("rst_tx", {7'b0, tx_out}, 8'h01);
        reset = 1'b0;

        // Single send of A5
        ctrl_bits = 8'h02;
        drive();
        tick();
        data_in = 8'hA5;
        req = 1'b1;
        drive();
        tick();
        chk("t1_ack_n", status_out, 8'h04);
        tick();
        chk("t1_ack_n1", status_out, 8'h11);
        wait_start("t1_start");
        check_frame(8'hA5, 1'b0, st0, st1);
        chk("t1_busy", st0, 8'h0D);
        chk("t1_done", status_out, 8'h05);

        // Fill while disabled, fifth request held
        ctrl_bits = 8'h00;
        for (int k = 1; k <= 5; k++) send(8'(k));
        chk("t2_full", status_out, 8'h43);
        ctrl_bits = 8'h02;
        drive();
        wait_start("t2_start");
        check_frame(8'h01, 1'b0, st0, st1);
        chk("t2_pop_first", st0, 8'h39);
        chk("t2_push_fifth", st1, 8'h4A);
        for (int k = 2; k <= 5; k++) check_frame(8'(k), 1'b0, st0, st1);
        chk("t2_done", status_out, 8'h04);

        // Flush with a frame in flight
        send(8'h11);
        fork
            begin
                wait_start("t3_start");
                check_frame(8'h11, 1'b0, a0, a1);
                check_frame(8'h55, 1'b0, a0, a1);
            end
            begin
                send(8'h22);
                send(8'h33);
                send(8'h44);
                chk("t3_level3", {5'b0, status_out[6:4]}, 8'h03);
                old_req = req;
                data_in = 8'h55;
                req = ~req;
                ctrl_bits = 8'h06;
                drive();
                tick();
                tick();
                chk("t3_flushed", status_out, 8'h0C | {7'b0, old_req});
                ctrl_bits = 8'h02;
                drive();
                tick();
                chk("t3_ack_held", {7'b0, status_out[0]}, {7'b0, old_req});
                tick();
                chk("t3_ack_after", {7'b0, status_out[0]}, {7'b0, req});
            end
        join
        chk("t3_done", status_out, 8'h04 | {7'b0, req});
        check_idle("t3_idle", 30);

        // Reset during data bit 3
        send(8'h00);
        wait_start("t4_start");
        repeat (17) tick();
        chk("t4_pre", {7'b0, tx_out}, 8'h00);
        reset = 1'b1;
        ctrl_bits = '0;
        req = 1'b0;
        ctrl_in = '0;
        data_in = '0;
        tick();
        chk("t4_tx", {7'b0, tx_out}, 8'h01);
        chk("t4_status", status_out, 8'h04);
        tick();
        reset = 1'b0;
        check_idle("t4_idle", 60);
        chk("t4_status_after", status_out, 8'h04);

`ifdef PORT_TX_PARITY_EN
        ctrl_bits = 8'h0A;
        send(8'h07);
        wait_start("t5_odd_start");
        check_frame(8'h07, 1'b0, st0, st1);
        ctrl_bits = 8'h02;
        send(8'h07);
        wait_start("t5_even_start");
        check_frame(8'h07, 1'b1, st0, st1);
        chk("t5_perr_clear", {7'b0, status_out[7]}, 8'h00);
        ctrl_bits = 8'h12;
        send(8'h07);
        wait_start("t5_force_start");
        check_frame(8'h07, 1'b0, st0, st1);
        chk("t5_perr_set", {7'b0, status_out[7]}, 8'h01);
        ctrl_bits = 8'h02;
        drive();
        repeat (5) tick();
        chk("t5_perr_sticky", {7'b0, status_out[7]}, 8'h01);
        ctrl_bits = 8'h06;
        drive();
        tick();
        ctrl_bits = 8'h02;
        drive();
        repeat (2) tick();
        chk("t5_perr_flushed", {7'b0, status_out[7]}, 8'h00);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/port_tx_link.md
Name: port_tx_link

Overview:
- Peripheral on the far side of the CPU's memory-less port interface.
- Consumes two CPU output-port registers: data byte and control/toggle handshake.
- Returns status on one CPU input-port byte.
- Buffers bytes in a small FIFO and serialises them on a UART-style line (8N1), so programs can stream bytes without cycle-counting loops.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..255.
- FIFO_DEPTH, 4, byte entries; power of two, 2..4. The level must fit 3 bits.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- ctrl_in  input  8  from a CPU output register. Bit0 req toggle, bit1 tx_enable, bit2 flush, bits7:3 ignored.
- data_in  input  8  from a CPU output register; byte to send.
- status_out  output  8  to a CPU input port. Bit0 ack toggle, bit1 full, bit2 empty, bit3 busy, bits6:4 FIFO level, bit7 parity_err_sticky (0 unless feature compiled in).
- tx_out  output  1  serial line, idle high.

Behaviour:
- Reset (sync, active-high) sets: tx_out=1, ack=0, FIFO empty, FSM=IDLE, status_out=8'h04. Reset mid-frame aborts the frame; tx_out=1 the next cycle.
- Input stage: ctrl_in and data_in are registered every cycle (ctrl_q, data_q). All decisions use the registered copies.
- Request pending: ctrl_q[0] != ack.
- Push: pending, flush=0, FIFO not full (registered full) -> write data_q, flip ack.
  - Latency: the toggle on ctrl_in before edge N is captured at N; push and ack flip happen at N+1; ack is visible on status_out after N+1.
- Pending while full: the request is held and not acked; it is pushed on the first cycle full=0. No overflow and no loss.
- Simultaneous push and pop: level unchanged. A pop on a full FIFO does not enable a push in the same cycle.
- Flush (ctrl_q[2]=1, level-sensitive):
  - FIFO level forced to 0 every cycle.
  - Pending requests are neither pushed nor acked.
  - An in-flight frame completes normally.
- FSM states IDLE, START, DATA, STOP. A bit counter (0..7) and a baud counter (0..CLKS_PER_BIT-1) drive the sequence.
  - IDLE: tx_out=1. If tx_enable and FIFO not empty -> pop into shift register, go to START.
  - START: tx_out=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: LSB first, each bit CLKS_PER_BIT cycles; after bit 7 -> STOP.
  - STOP: tx_out=1 for CLKS_PER_BIT cycles -> IDLE. A new frame may start the next cycle (back-to-back, no extra idle).
- tx_enable=0: the current frame finishes; no new frame starts. Pushes still accepted.
- busy=1 in any state except IDLE.
- full = level==FIFO_DEPTH; empty = level==0.
- All status bits are registered outputs, updated once per cycle.

Optional Feature:
- Macro PORT_TX_PARITY_EN.
- Defined:
  - ctrl_in[3] selects parity: 0 even, 1 odd.
  - A PARITY state is inserted between DATA and STOP; frame becomes 8E1/8O1, 11 bits.
  - ctrl_in[4] forces wrong parity for the next frame, as a line test. Parity is latched on pop.
  - status_out[7] sets when a forced-wrong frame completes; it clears on flush.
- Undefined: no PARITY state; ctrl bits 3/4 ignored; status_out[7] tied 0.

Decomposition:
- Package port_io_pkg:
  - ctrl bit indices (REQ, EN, FLUSH, PAR_ODD, PAR_FORCE)
  - status bit indices and the level field position
  - FSM state encoding
  - reset status constant 8'h04
- One sub-module: port_fifo. Synchronous FIFO, parameter DEPTH, push/pop/flush, registered full/empty/level.
- FSM, handshake and status logic stay in the top.

Test Plan (all with CLKS_PER_BIT=4):
- Reset, then one send: data_in=8'hA5, toggle ctrl_in 8'h02->8'h03.
  - ack=1 two cycles after the toggle.
  - tx_out: 0, then 1,0,1,0,0,1,0,1, then 1; 4 cycles per bit.
  - status returns to 8'h05 (ack=1, empty, idle).
- Fill while disabled: five toggles with tx_enable=0 and data 1..5.
  - Level reaches 4, full=1.
  - The fifth toggle stays unacked.
  - Set tx_enable=1: the first pop frees a slot, the fifth byte is acked and pushed next cycle, and bytes 1..5 go out back-to-back in order.
- Flush: level=3, assert flush for one cycle while a frame is in flight.
  - Level goes to 0; the in-flight frame completes; the remaining bytes are never sent.
  - A toggle during flush is acked only after flush drops.
- Reset mid-frame during DATA bit 3.
  - tx_out=1 next cycle; status_out=8'h04.
  - With ctrl_in held 0, no spurious send follows.
- Parity (PORT_TX_PARITY_EN defined): data 8'h07 with odd parity gives parity bit 0; even gives 1.
  - With force set, the inverted bit is sent and status_out[7]=1 until flush.
